// File: rtl/cached_ram.sv
`default_nettype none
// ============================================================================
// Module   : cached_ram
// Purpose  : Single-port RAM behind a direct-mapped, write-through,
//            no-write-allocate cache. The backing array is multi-cycle.
//            Optional hit/miss counters: define CACHED_RAM_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module cached_ram #(
    parameter int DATA_W  = 10,
    parameter int ADDR_W  = 10,
    parameter int INDEX_W = 3,
    parameter int MEM_LAT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_hit
`ifdef CACHED_RAM_STATS_EN
    ,
    output logic [15:0]       hit_count,
    output logic [15:0]       miss_count
`endif
);

    localparam int LINES = 1 << INDEX_W;
    localparam int DEPTH = 1 << ADDR_W;
    localparam int TAG_W = ADDR_W - INDEX_W;
    localparam int CNT_W = $clog2(MEM_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOOKUP = 2'd1,
        S_FILL   = 2'd2,
        S_WRITE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                hit_q, hit_d;
    logic                resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
    logic                resp_hit_q, resp_hit_d;
    logic [LINES-1:0]    valid_q, valid_d;

    // Tag/data storage and the backing array are deliberately outside reset.
    logic [TAG_W-1:0]    tag_q  [LINES];
    logic [DATA_W-1:0]   data_q [LINES];
    logic [DATA_W-1:0]   mem_q  [DEPTH] = '{default: '0};

    logic [INDEX_W-1:0]  idx;
    logic [TAG_W-1:0]    tag;
    logic                lookup_hit;
    logic [DATA_W-1:0]   mem_rd;
    logic                line_fill;
    logic                line_upd;
    logic                mem_we;

    assign idx        = addr_q[INDEX_W-1:0];
    assign tag        = addr_q[ADDR_W-1:INDEX_W];
    assign lookup_hit = valid_q[idx] && (tag_q[idx] == tag);
    assign mem_rd     = mem_q[addr_q];

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_hit   = resp_hit_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        hit_d        = hit_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_hit_d   = resp_hit_q;
        valid_d      = valid_q;
        line_fill    = 1'b0;
        line_upd     = 1'b0;
        mem_we       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                cnt_d = '0;
                if (we_q) begin
                    hit_d   = lookup_hit;
                    state_d = S_WRITE;
                end else if (lookup_hit) begin
                    resp_valid_d = 1'b1;
                    resp_rdata_d = data_q[idx];
                    resp_hit_d   = 1'b1;
                    state_d      = S_IDLE;
                end else begin
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                if (cnt_q == CNT_LAST) begin
                    line_fill    = 1'b1;
                    valid_d[idx] = 1'b1;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = mem_rd;
                    resp_hit_d   = 1'b0;
                    state_d      = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WRITE: begin
                if (cnt_q == CNT_LAST) begin
                    mem_we       = 1'b1;
                    line_upd     = hit_q;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = wdata_q;
                    resp_hit_d   = hit_q;
                    state_d      = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            hit_q        <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_hit_q   <= 1'b0;
            valid_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            hit_q        <= hit_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_hit_q   <= resp_hit_d;
            valid_q      <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (line_fill) begin
            tag_q[idx]  <= tag;
            data_q[idx] <= mem_rd;
        end else if (line_upd) begin
            data_q[idx] <= wdata_q;
        end
    end

    always @(posedge clk) begin
        if (mem_we) begin
            mem_q[addr_q] <= wdata_q;
        end
    end

`ifdef CACHED_RAM_STATS_EN
    logic [15:0] hit_count_q, miss_count_q;

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else if (state_q == S_LOOKUP) begin
            if (lookup_hit && hit_count_q != 16'hFFFF) begin
                hit_count_q <= hit_count_q + 16'd1;
            end else if (!lookup_hit && miss_count_q != 16'hFFFF) begin
                miss_count_q <= miss_count_q + 16'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_cached_ram.sv
`default_nettype none
// ============================================================================
// Module   : tb_cached_ram
// Purpose  : Directed self-checking bench for cached_ram (default parameters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cached_ram;

    logic       clk;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic       req_we;
    logic [9:0] req_addr;
    logic [9:0] req_wdata;
    logic       resp_valid;
    logic [9:0] resp_rdata;
    logic       resp_hit;
`ifdef CACHED_RAM_STATS_EN
    logic [15:0] hit_count;
    logic [15:0] miss_count;
`endif

    int checks   = 0;
    int failures = 0;

    cached_ram #(
        .DATA_W (10),
        .ADDR_W (10),
        .INDEX_W(3),
        .MEM_LAT(4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .resp_valid(resp_valid),
        .resp_rdata(resp_rdata),
        .resp_hit  (resp_hit)
`ifdef CACHED_RAM_STATS_EN
        ,
        .hit_count (hit_count),
        .miss_count(miss_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one request; lat is the edge count after E0 at which resp_valid is
    // seen (0 = no response within budget), busy counts cycles with req_ready=0.
    task automatic access(input logic we, input logic [9:0] addr, input logic [9:0] wd,
                          output int lat, output int busy,
                          output logic [9:0] rd, output logic hit);
        lat  = 0;
        busy = 0;
        rd   = 'x;
        hit  = 1'bx;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        if (req_ready === 1'b0) busy++;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (resp_valid === 1'b1) begin
                lat = i;
                rd  = resp_rdata;
                hit = resp_hit;
                break;
            end
            if (req_ready === 1'b0) busy++;
        end
    endtask

    int         lat;
    int         busy;
    logic [9:0] rd;
    logic       hit;
    logic       seen;

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready",      32'(req_ready),  32'd1);
        chk("reset_resp_valid", 32'(resp_valid), 32'd0);
        chk("reset_rdata",      32'(resp_rdata), 32'd0);
        chk("reset_hit",        32'(resp_hit),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Cold read miss of address 5
        access(1'b0, 10'd5, 10'd0, lat, busy, rd, hit);
        chk("s1_lat",   32'(lat),  32'd5);
        chk("s1_busy",  32'(busy), 32'd5);
        chk("s1_rdata", 32'(rd),   32'd0);
        chk("s1_hit",   32'(hit),  32'd0);

        // Write hit then read hit
        access(1'b1, 10'd5, 10'h155, lat, busy, rd, hit);
        chk("s2w_lat",   32'(lat), 32'd5);
        chk("s2w_rdata", 32'(rd),  32'h155);
        chk("s2w_hit",   32'(hit), 32'd1);
        access(1'b0, 10'd5, 10'd0, lat, busy, rd, hit);
        chk("s2r_lat",   32'(lat),  32'd1);
        chk("s2r_busy",  32'(busy), 32'd1);
        chk("s2r_rdata", 32'(rd),   32'h155);
        chk("s2r_hit",   32'(hit),  32'd1);

        // Conflict on index 5: evict, then re-read shows write-through data
        access(1'b0, 10'd13, 10'd0, lat, busy, rd, hit);
        chk("s3a_lat",   32'(lat), 32'd5);
        chk("s3a_rdata", 32'(rd),  32'd0);
        chk("s3a_hit",   32'(hit), 32'd0);
        access(1'b0, 10'd5, 10'd0, lat, busy, rd, hit);
        chk("s3b_lat",   32'(lat), 32'd5);
        chk("s3b_rdata", 32'(rd),  32'h155);
        chk("s3b_hit",   32'(hit), 32'd0);

        // Write miss does not allocate
        access(1'b1, 10'd1023, 10'h3FF, lat, busy, rd, hit);
        chk("s4w_lat",   32'(lat), 32'd5);
        chk("s4w_rdata", 32'(rd),  32'h3FF);
        chk("s4w_hit",   32'(hit), 32'd0);
        access(1'b0, 10'd1023, 10'd0, lat, busy, rd, hit);
        chk("s4r1_lat",   32'(lat), 32'd5);
        chk("s4r1_rdata", 32'(rd),  32'h3FF);
        chk("s4r1_hit",   32'(hit), 32'd0);
        access(1'b0, 10'd1023, 10'd0, lat, busy, rd, hit);
        chk("s4r2_lat",   32'(lat), 32'd1);
        chk("s4r2_rdata", 32'(rd),  32'h3FF);
        chk("s4r2_hit",   32'(hit), 32'd1);

        // Reset two cycles into WRITE: no response, no commit
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 10'd20;
        req_wdata = 10'h2AA;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (resp_valid === 1'b1) seen = 1'b1;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (resp_valid === 1'b1) seen = 1'b1;
        end
        chk("s5_no_resp", 32'(seen),      32'd0);
        chk("s5_ready",   32'(req_ready), 32'd1);
        access(1'b0, 10'd20, 10'd0, lat, busy, rd, hit);
        chk("s5r_lat",   32'(lat), 32'd5);
        chk("s5r_rdata", 32'(rd),  32'd0);
        chk("s5r_hit",   32'(hit), 32'd0);

        // Fresh reset: read 5 (miss), write 5 (hit), read 5 (hit)
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        access(1'b0, 10'd5, 10'd0, lat, busy, rd, hit);
        chk("s6r1_rdata", 32'(rd),  32'h155);
        chk("s6r1_hit",   32'(hit), 32'd0);
        access(1'b1, 10'd5, 10'h0A5, lat, busy, rd, hit);
        chk("s6w_hit",    32'(hit), 32'd1);
        access(1'b0, 10'd5, 10'd0, lat, busy, rd, hit);
        chk("s6r2_lat",   32'(lat), 32'd1);
        chk("s6r2_rdata", 32'(rd),  32'h0A5);
        chk("s6r2_hit",   32'(hit), 32'd1);
`ifdef CACHED_RAM_STATS_EN
        chk("s6_hit_count",  32'(hit_count),  32'd2);
        chk("s6_miss_count", 32'(miss_count), 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cached_ram.md
# cached_ram

Parametrised single-port RAM with a direct-mapped, write-through, no-write-allocate cache in front of a multi-cycle backing array. It replaces the bare asynchronous-read RAM in the memory subsystem.
- A valid/ready request port feeds it.
- Read hits are served in one cycle.
- Misses and all writes pay the backing-array latency.
- The backing array is internal to the block, so the unit is self-contained for the processor datapath.

## Interface
- `DATA_W`, default 10: data word width.
- `ADDR_W`, default 10: word address width. The backing array has 2^ADDR_W entries.
- `INDEX_W`, default 3: cache index width. The cache has 2^INDEX_W lines of one word each. Must be less than `ADDR_W`.
- `MEM_LAT`, default 4: backing-array access latency in cycles. Must be at least 1.

Ports:
- `clk` (in, 1): clock, rising-edge.
- `rst_n` (in, 1): asynchronous, active-low reset.
- `req_valid` (in, 1): request present.
- `req_ready` (out, 1): block can accept a request.
- `req_we` (in, 1): 1 for write, 0 for read.
- `req_addr` (in, `ADDR_W`): word address.
- `req_wdata` (in, `DATA_W`): write data.
- `resp_valid` (out, 1): one-cycle completion pulse.
- `resp_rdata` (out, `DATA_W`): read data, or the written data for a write acknowledge.
- `resp_hit` (out, 1): qualifies `resp_valid`; 1 when the access hit in the cache.
- `hit_count`, `miss_count` (out, 16 each): present only with `CACHED_RAM_STATS_EN`.

## Operation
- **Address split:**
  - index = `req_addr[INDEX_W-1:0]`.
  - tag = `req_addr[ADDR_W-1:INDEX_W]`, which is `ADDR_W-INDEX_W` bits.
  - Each cache line holds a valid bit, a tag and a data word.
- **States:** IDLE, LOOKUP, FILL, WRITE.
- **IDLE:**
  - `req_ready`=1.
  - A request is accepted on the edge where `req_valid` and `req_ready` are both 1.
  - On acceptance, `req_we`, `req_addr` and `req_wdata` are latched and the state goes to LOOKUP.
- **LOOKUP:**
  - `req_ready`=0.
  - Hit = the line's valid bit is set and its tag matches the latched tag.
  - Read hit: the response is registered with `resp_rdata` = line data and `resp_hit`=1, then the state returns to IDLE.
  - Read miss: go to FILL.
  - Any write: go to WRITE and record the hit/miss result.
- **FILL:**
  - A counter runs for `MEM_LAT` cycles.
  - On the final cycle, the backing word is read and the line is written with data, tag and valid=1. This evicts any previous occupant; no write-back is needed.
  - The response is registered with `resp_hit`=0, then the state returns to IDLE.
- **WRITE:**
  - A counter runs for `MEM_LAT` cycles.
  - On the final cycle, `wdata` is committed to the backing array.
  - If the write hit, the line data is also updated. A write miss does not allocate a line.
  - The response is registered with `resp_rdata` = `wdata` and `resp_hit` = the recorded result, then the state returns to IDLE.
- **No response backpressure:** the consumer must take `resp_valid` when it is pulsed.
- **Backing array:** initialises to all zeros at time 0 and is not cleared by reset. Cache data and tags are not cleared by reset either; only the valid bits are.

## Timing
- Let E0 be the acceptance edge.
  - A read hit drives `resp_valid` high for the cycle after edge E0+1.
  - A read miss or any write drives `resp_valid` high for the cycle after edge E0+1+`MEM_LAT`.
- `req_ready` returns to 1 in the same cycle as `resp_valid`. A new request may be accepted at the edge ending that cycle.
- **Reset values:**
  - Outputs: `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_hit`=0, counters=0.
  - Internal: all line valid bits=0, state=IDLE, latency counter=0.
- **Reset mid-operation:**
  - The operation is abandoned and no response is issued.
  - A WRITE aborted before its final cycle does not commit to the backing array.
  - A FILL aborted before its final cycle leaves the line invalid.
- `req_*` inputs are only sampled at the acceptance edge and are ignored while `req_ready`=0.

## Configuration
- `CACHED_RAM_STATS_EN` defined:
  - `hit_count` and `miss_count` ports exist.
  - Each increments by 1 in LOOKUP for every access, read or write, according to the hit result.
  - Each saturates at 16'hFFFF.
  - Both clear on reset.
- Not defined: the ports and the counter logic are absent. All other behaviour is identical.

## Test plan
Defaults for all scenarios: `DATA_W`=10, `ADDR_W`=10, `INDEX_W`=3, `MEM_LAT`=4.
1. Reset, then read address 5 → `resp_valid` after E0+5 with `resp_rdata`=0 and `resp_hit`=0; `req_ready` is 0 for the 5 cycles before that.
2. After scenario 1, write 10'h155 to address 5 → acknowledge after E0+5 with `resp_hit`=1. Then read address 5 → response after E0+1 with `resp_rdata`=10'h155 and `resp_hit`=1.
3. After scenario 2, read address 13 (same index, tag 1) → miss returning 0. Then read address 5 → miss returning 10'h155, confirming write-through.
4. Write 10'h3FF to address 1023 with line 7 invalid → `resp_hit`=0 and no allocation. Then read 1023 → miss returning 10'h3FF. Then read 1023 again → hit returning 10'h3FF.
5. Start a write of 10'h2AA to address 20 and pull `rst_n` low 2 cycles into WRITE → no `resp_valid`; `req_ready`=1 after release. Then read address 20 → miss returning 0.
6. With `CACHED_RAM_STATS_EN`: run the sequence read 5, write 5, read 5 from reset → `hit_count`=2, `miss_count`=1. Force 65,536 hits → `hit_count` stays 16'hFFFF.
